// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO pair; results are computed at the Start
// edge, held as pending, and committed when the latency counter expires. Optional madd/msub: MDU_MADD_EN.
module mdu_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [3:0]       MDOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam logic [3:0] OP_MULT  = 4'b0001;
  localparam logic [3:0] OP_MULTU = 4'b0010;
  localparam logic [3:0] OP_DIV   = 4'b0011;
  localparam logic [3:0] OP_DIVU  = 4'b0100;
  localparam logic [3:0] OP_MTHI  = 4'b0101;
  localparam logic [3:0] OP_MTLO  = 4'b0110;
  localparam logic [3:0] OP_MADD  = 4'b0111;
  localparam logic [3:0] OP_MSUB  = 4'b1000;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                 r_state, w_next;
  logic [4:0]             r_cnt;
  logic [2*WIDTH-1:0]     r_pend;

  logic                   w_is_mul, w_is_div, w_accept;
  logic [4:0]             w_cycles;
  logic [2*WIDTH-1:0]     w_result;

  logic signed [2*WIDTH-1:0] w_ax, w_bx, w_prod_s;
  logic [2*WIDTH-1:0]        w_prod_u;

  logic                   w_div_signed;
  logic [WIDTH-1:0]       w_dvd, w_dvs, w_dvs_safe, w_q, w_r, w_q_fix, w_r_fix;

  // Operation classification
  always_comb begin
    w_is_mul = 1'b0;
    w_is_div = 1'b0;
    unique case (MDOp)
      OP_MULT, OP_MULTU: w_is_mul = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD, OP_MSUB:  w_is_mul = 1'b1;
`endif
      OP_DIV, OP_DIVU:   w_is_div = 1'b1;
      default: ;
    endcase
  end

  assign w_accept = (r_state == S_IDLE) && Start && (w_is_mul || w_is_div);
  assign w_cycles = w_is_div ? 5'(DIV_CYCLES) : 5'(MULT_CYCLES);

  assign w_ax     = $signed({{WIDTH{A[WIDTH-1]}}, A});
  assign w_bx     = $signed({{WIDTH{B[WIDTH-1]}}, B});
  assign w_prod_s = w_ax * w_bx;
  assign w_prod_u = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};

  // Shared unsigned divider on magnitudes; sign fix-up afterwards. The most-negative / -1
  // case falls out as quotient=A, remainder=0 without a special path.
  assign w_div_signed = (MDOp == OP_DIV);
  assign w_dvd        = (w_div_signed && A[WIDTH-1]) ? -A : A;
  assign w_dvs        = (w_div_signed && B[WIDTH-1]) ? -B : B;
  assign w_dvs_safe   = (B == '0) ? WIDTH'(1) : w_dvs;
  assign w_q          = w_dvd / w_dvs_safe;
  assign w_r          = w_dvd % w_dvs_safe;
  assign w_q_fix      = (w_div_signed && (A[WIDTH-1] ^ B[WIDTH-1])) ? -w_q : w_q;
  assign w_r_fix      = (w_div_signed && A[WIDTH-1]) ? -w_r : w_r;

  always_comb begin
    w_result = '0;
    unique case (MDOp)
      OP_MULT:  w_result = w_prod_s;
      OP_MULTU: w_result = w_prod_u;
      OP_DIV, OP_DIVU:
        w_result = (B == '0) ? {A, {WIDTH{1'b1}}} : {w_r_fix, w_q_fix};
`ifdef MDU_MADD_EN
      OP_MADD:  w_result = {HI, LO} + w_prod_s;
      OP_MSUB:  w_result = {HI, LO} - w_prod_s;
`endif
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept) w_next = S_RUN;
      S_RUN:  if (r_cnt == 5'd1) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    Busy = (r_state == S_RUN);
  end

  // Datapath: pending result, counter, HI/LO
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_pend <= '0;
      HI     <= '0;
      LO     <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_pend <= w_result;
            r_cnt  <= w_cycles;
          end else if (Start && MDOp == OP_MTHI) begin
            HI <= A;
          end else if (Start && MDOp == OP_MTLO) begin
            LO <= A;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt - 5'd1;
          if (r_cnt == 5'd1) {HI, LO} <= r_pend;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Parametrised multi-cycle multiply/divide unit for the pipelined CPU; sits beside the ALU in the EX stage.
- Owns the HI/LO register pair.
- Performs signed and unsigned multiply/divide with configurable latency, plus MTHI/MTLO writes.
- Exposes Busy so the hazard unit can stall dependent MF/MT/MD instructions.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits (legal range 8..64).
- MULT_CYCLES, 5, Busy cycles for mult/multu/madd/msub (legal range 1..31).
- DIV_CYCLES, 10, Busy cycles for div/divu (legal range 1..31).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; clears all state
- Start  input  1  EX-stage instruction is an MD op; qualifies MDOp
- MDOp  input  4  operation select
- A  input  WIDTH  rs operand
- B  input  WIDTH  rt operand
- Busy  output  1  operation in flight; HI/LO not yet valid
- HI  output  WIDTH  HI register, registered
- LO  output  WIDTH  LO register, registered

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: Busy=0, HI=0, LO=0, internal counter=0, pending result=0.
- MDOp encoding:
  - 0000 none
  - 0001 mult (signed)
  - 0010 multu
  - 0011 div (signed)
  - 0100 divu
  - 0101 mthi
  - 0110 mtlo
  - 0111 madd (optional feature)
  - 1000 msub (optional feature)
  - Others: no-op.
- States: IDLE, RUN.
- IDLE, Start=1 with a mult/div op:
  - Compute full result from A/B at the edge.
  - Latch the result into pending HI/LO.
  - Load counter with MULT_CYCLES or DIV_CYCLES.
  - Go to RUN.
  - Busy=1 from the next cycle.
- RUN:
  - Counter decrements each edge.
  - On the edge where the counter goes 1->0: commit pending to HI/LO, Busy falls, return to IDLE.
  - Net timing: Start sampled at edge 0, Busy high for exactly N cycles, new HI/LO visible on the first cycle Busy=0.
- Start during RUN: ignored for all ops, including mthi/mtlo. The hazard unit must stall, so this never occurs in a legal program.
- mthi/mtlo in IDLE: HI (or LO) <= A at the edge; the other register is unchanged; Busy stays 0; no RUN state.
- Multiply arithmetic: full 2*WIDTH product; HI=upper WIDTH bits, LO=lower WIDTH bits. Signed ops use sign-extended operands.
- Divide arithmetic:
  - LO=quotient, HI=remainder.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
- Divide by zero (B=0): LO=all ones, HI=A, for both signed and unsigned; Busy cycle count is unchanged.
- Signed overflow (A=most-negative, B=-1): LO=A, HI=0.
- Reset asserted during RUN: abort immediately; HI/LO=0; pending result is discarded.
- Start and reset in the same cycle: reset wins; no operation is started.
- Start with MDOp=0000 or an undefined code: no state change.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: MDOp 0111/1000 accepted.
  - madd: {HI,LO} <= {HI,LO} + signed(A)*signed(B).
  - msub: {HI,LO} <= {HI,LO} - signed(A)*signed(B).
  - Arithmetic is modulo 2^(2*WIDTH).
  - The accumulate base is HI/LO at the Start edge.
  - Latency is MULT_CYCLES.
- Undefined: 0111/1000 behave as no-op. No accumulate adder is synthesised.

Test Plan:
- Reset, then mult with A=0xFFFFFFFF, B=0x00000002 (WIDTH=32, MULT_CYCLES=5) -> Busy high exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFE. Repeat with multu -> HI=0x00000001, LO=0xFFFFFFFE.
- div with A=-7 (0xFFFFFFF9), B=2 -> after 10 Busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu with A=7, B=2 -> LO=3, HI=1.
- divu with A=0x1234, B=0 -> LO=0xFFFFFFFF, HI=0x1234. div with A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- Set HI/LO via mthi 0xAAAA and mtlo 0x5555 (Busy never rises). Start mult 3*4, then issue mtlo 0x9999 at Busy cycle 2 -> mtlo ignored; final HI=0, LO=12.
- Start div 100/3, assert reset at Busy cycle 4 -> next cycle Busy=0, HI=0, LO=0, no late commit.
- With MDU_MADD_EN: HI=0, LO=10, madd A=-2, B=3 -> HI=0, LO=4. msub A=2, B=3 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE. Without the macro: HI/LO unchanged, Busy stays 0.
